// File: rtl/edge_threshold.sv
// Serial |Gx|+|Gy| combiner: saturates each pixel to OUT_W bits and thresholds it into an edge map.
// Optional edge counter enabled by defining EDGE_THRESHOLD_COUNT_EN; otherwise edge_cnt is tied to 0.
module edge_threshold #(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int IN_W  = 9,
   parameter int OUT_W = 8,
   localparam int N     = ROWS * COLS,
   localparam int IDX_W = $clog2(N),
   localparam int CNT_W = $clog2(N + 1)
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      comb_en,
   input  logic [OUT_W-1:0]                          threshold,
   input  logic [ROWS-1:0][COLS-1:0][IN_W-1:0]       x_in,
   input  logic [ROWS-1:0][COLS-1:0][IN_W-1:0]       y_in,
   output logic [ROWS-1:0][COLS-1:0][OUT_W-1:0]      pix_out,
   output logic [N-1:0]                              edge_map,
   output logic [CNT_W-1:0]                          edge_cnt,
   output logic                                      busy,
   output logic                                      comb_done
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                 state_reg;
   logic [IDX_W-1:0]       idx_reg;
   logic [OUT_W-1:0]       thr_reg;
   logic [IN_W-1:0]        x_reg [N];
   logic [IN_W-1:0]        y_reg [N];
   logic [N*OUT_W-1:0]     pix_reg;
   logic [N-1:0]           map_reg;

   logic [N*IN_W-1:0]      x_bits;
   logic [N*IN_W-1:0]      y_bits;
   logic [IN_W-1:0]        x_el [N];
   logic [IN_W-1:0]        y_el [N];

   logic                   start;
   logic                   calc;
   logic [IN_W:0]          sum_next;
   logic [OUT_W-1:0]       pix_next;
   logic                   edge_next;

   localparam logic [IN_W:0] SAT = (IN_W+1)'((1 << OUT_W) - 1);

   assign x_bits = x_in;
   assign y_bits = y_in;

   // Element k of the row-major input tile sits at flat offset k*IN_W.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_el
         assign x_el[gi] = x_bits[gi*IN_W +: IN_W];
         assign y_el[gi] = y_bits[gi*IN_W +: IN_W];
      end
   endgenerate

   assign start = (state_reg == IDLE) && comb_en;
   assign calc  = (state_reg == CALC);

   always_comb begin
      sum_next  = {1'b0, x_reg[idx_reg]} + {1'b0, y_reg[idx_reg]};
      pix_next  = (sum_next > SAT) ? {OUT_W{1'b1}} : sum_next[OUT_W-1:0];
      edge_next = (pix_next > thr_reg);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         busy      <= 1'b0;
         comb_done <= 1'b0;
      end else begin
         comb_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (comb_en) begin
                  idx_reg   <= '0;
                  busy      <= 1'b1;
                  state_reg <= CALC;
               end
            end
            CALC: begin
               if (idx_reg == IDX_W'(N - 1)) begin
                  state_reg <= DONE;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            DONE: begin
               comb_done <= 1'b1;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Operand capture has no reset: the tile is only consumed after a start reloads it.
   always_ff @(posedge clk) begin
      if (!rst && start) begin
         x_reg   <= x_el;
         y_reg   <= y_el;
         thr_reg <= threshold;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || start) begin
         pix_reg <= '0;
         map_reg <= '0;
      end else if (calc) begin
         map_reg[idx_reg] <= edge_next;
         for (int i = 0; i < N; i++) begin
            if (idx_reg == IDX_W'(i)) begin
               pix_reg[i*OUT_W +: OUT_W] <= pix_next;
            end
         end
      end
   end

   assign pix_out  = pix_reg;
   assign edge_map = map_reg;

`ifdef EDGE_THRESHOLD_COUNT_EN
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || start) begin
         cnt_reg <= '0;
      end else if (calc) begin
         cnt_reg <= cnt_reg + CNT_W'(edge_next);
      end
   end

   assign edge_cnt = cnt_reg;
`else
   assign edge_cnt = '0;
`endif

endmodule

// File: tb/tb_edge_threshold.sv
// Randomized self-checking bench for edge_threshold against an arithmetic tile model.
module tb_edge_threshold;

   localparam int ROWS = 4, COLS = 4, IN_W = 9, OUT_W = 8;
   localparam int N = ROWS * COLS;
   localparam int CNT_W = $clog2(N + 1);

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 comb_en = 1'b0;
   logic [OUT_W-1:0]     threshold = '0;
   logic [N*IN_W-1:0]    x_bits = '0;
   logic [N*IN_W-1:0]    y_bits = '0;
   logic [N*OUT_W-1:0]   pix_bits;
   logic [N-1:0]         edge_map;
   logic [CNT_W-1:0]     edge_cnt;
   logic                 busy;
   logic                 comb_done;

   int errors = 0;
   int checks = 0;

   int xm [N];
   int ym [N];
   int exp_pix [N];
   logic [N-1:0] exp_map;
   int exp_cnt;

   edge_threshold #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst), .comb_en(comb_en), .threshold(threshold),
      .x_in(x_bits), .y_in(y_bits), .pix_out(pix_bits), .edge_map(edge_map),
      .edge_cnt(edge_cnt), .busy(busy), .comb_done(comb_done)
   );

   always #5 clk = ~clk;

   // Reference: each pixel is min(x+y, 255); edge when strictly above threshold.
   task automatic compute_model(input int thr);
      int popc;
      popc = 0;
      exp_map = '0;
      for (int k = 0; k < N; k++) begin
         exp_pix[k] = (xm[k] + ym[k] > 255) ? 255 : xm[k] + ym[k];
         if (exp_pix[k] > thr) begin
            exp_map[k] = 1'b1;
            popc++;
         end
      end
`ifdef EDGE_THRESHOLD_COUNT_EN
      exp_cnt = popc;
`else
      exp_cnt = 0;
`endif
   endtask

   task automatic apply_inputs(input int thr);
      for (int k = 0; k < N; k++) begin
         x_bits[k*IN_W +: IN_W] = IN_W'(xm[k]);
         y_bits[k*IN_W +: IN_W] = IN_W'(ym[k]);
      end
      threshold = OUT_W'(thr);
   endtask

   task automatic scramble_inputs();
      for (int k = 0; k < N; k++) begin
         x_bits[k*IN_W +: IN_W] = IN_W'($urandom_range(0, 256));
         y_bits[k*IN_W +: IN_W] = IN_W'($urandom_range(0, 256));
      end
      threshold = OUT_W'($urandom_range(0, 255));
   endtask

   task automatic random_tile();
      for (int k = 0; k < N; k++) begin
         xm[k] = $urandom_range(0, 256);
         ym[k] = $urandom_range(0, 256);
      end
   endtask

   // Leaves the bench 1 time unit after E0.
   task automatic start_tile();
      comb_en = 1'b1;
      @(posedge clk); #1;
      comb_en = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         if (comb_done === 1'b1) begin
            lat = e;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (pix_bits !== '0 || edge_map !== '0 || edge_cnt !== '0 || busy !== 1'b0 || comb_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state pix=%h map=%h cnt=%0d busy=%b done=%b required all 0",
                  pix_bits, edge_map, edge_cnt, busy, comb_done);
      end
   endtask

   task automatic test_zero_timing();
      for (int k = 0; k < N; k++) begin xm[k] = 0; ym[k] = 0; end
      apply_inputs(0);
      start_tile();
      for (int e = 1; e <= 18; e++) begin
         @(posedge clk); #1;
         checks++;
         if (busy !== (e < 17) || comb_done !== (e == 17)) begin
            errors++;
            $display("FAIL zero_timing edge E%0d busy=%b done=%b required busy=%b done=%b",
                     e, busy, comb_done, (e < 17), (e == 17));
         end
      end
      checks++;
      if (pix_bits !== '0 || edge_map !== '0 || edge_cnt !== '0) begin
         errors++;
         $display("FAIL zero_result pix=%h map=%h cnt=%0d required 0", pix_bits, edge_map, edge_cnt);
      end
      $display("zero tile: busy/done timing checked over 18 edges");
   endtask

   task automatic test_directed();
      int lat;
      for (int k = 0; k < N; k++) begin xm[k] = 0; ym[k] = 0; end
      xm[0] = 200; ym[0] = 100; xm[5] = 3; ym[5] = 3;
      apply_inputs(5);
      compute_model(5);
      start_tile();
      scramble_inputs();
      wait_done(lat);
      checks++;
      if (lat != 17) begin
         errors++;
         $display("FAIL directed_latency got=%0d required=17", lat);
      end
      checks++;
      if (pix_bits[0 +: 8] !== 8'd255 || pix_bits[5*8 +: 8] !== 8'd6 || edge_map !== 16'h0021) begin
         errors++;
         $display("FAIL directed_pix p0=%0d p5=%0d map=%h required 255 6 0021",
                  pix_bits[0 +: 8], pix_bits[5*8 +: 8], edge_map);
      end
      checks++;
      if (edge_cnt !== CNT_W'(exp_cnt)) begin
         errors++;
         $display("FAIL directed_cnt got=%0d required=%0d", edge_cnt, exp_cnt);
      end
      $display("directed tile: map=%h cnt=%0d", edge_map, edge_cnt);
   endtask

   task automatic test_threshold_boundary();
      int lat;
      for (int t = 10; t >= 9; t--) begin
         for (int k = 0; k < N; k++) begin xm[k] = 10; ym[k] = 0; end
         apply_inputs(t);
         compute_model(t);
         start_tile();
         wait_done(lat);
         checks++;
         if (lat != 17 || edge_map !== ((t == 10) ? 16'h0000 : 16'hFFFF)) begin
            errors++;
            $display("FAIL thr_boundary thr=%0d lat=%0d map=%h required lat=17 map=%h",
                     t, lat, edge_map, (t == 10) ? 16'h0000 : 16'hFFFF);
         end
         checks++;
         if (edge_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL thr_cnt thr=%0d got=%0d required=%0d", t, edge_cnt, exp_cnt);
         end
         $display("threshold=%0d: map=%h cnt=%0d", t, edge_map, edge_cnt);
      end
   endtask

   task automatic test_saturation_ignore();
      int pulses, at;
      for (int k = 0; k < N; k++) begin xm[k] = 256; ym[k] = 256; end
      apply_inputs(254);
      start_tile();
      pulses = 0; at = -1;
      for (int e = 1; e <= 25; e++) begin
         if (e == 5) comb_en = 1'b1;
         @(posedge clk); #1;
         comb_en = 1'b0;
         if (comb_done === 1'b1) begin pulses++; at = e; end
      end
      checks++;
      if (pulses != 1 || at != 17 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_en pulses=%0d at=E%0d busy=%b required 1 pulse at E17 busy=0", pulses, at, busy);
      end
      for (int k = 0; k < N; k++) begin
         checks++;
         if (pix_bits[k*8 +: 8] !== 8'd255) begin
            errors++;
            $display("FAIL saturate pix[%0d] got=%0d required=255", k, pix_bits[k*8 +: 8]);
         end
      end
      $display("saturation tile: pulses=%0d map=%h", pulses, edge_map);
   endtask

   task automatic test_reset_abort();
      int lat, pulses;
      random_tile();
      apply_inputs(100);
      start_tile();
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (pix_bits !== '0 || edge_map !== '0 || edge_cnt !== '0 || busy !== 1'b0 || comb_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_state pix=%h map=%h cnt=%0d busy=%b done=%b required all 0",
                  pix_bits, edge_map, edge_cnt, busy, comb_done);
      end
      pulses = 0;
      for (int e = 0; e < 20; e++) begin
         @(posedge clk); #1;
         if (comb_done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL abort_no_done pulses=%0d required=0", pulses);
      end
      random_tile();
      apply_inputs(77);
      compute_model(77);
      start_tile();
      wait_done(lat);
      checks++;
      if (lat != 17 || edge_map !== exp_map || edge_cnt !== CNT_W'(exp_cnt)) begin
         errors++;
         $display("FAIL abort_restart lat=%0d map=%h cnt=%0d required 17 %h %0d",
                  lat, edge_map, edge_cnt, exp_map, exp_cnt);
      end
      $display("abort then restart: lat=%0d map=%h", lat, edge_map);
   endtask

   task automatic test_random();
      int lat, thr, bad;
      for (int t = 0; t < 6; t++) begin
         random_tile();
         thr = $urandom_range(0, 255);
         apply_inputs(thr);
         compute_model(thr);
         start_tile();
         scramble_inputs();
         wait_done(lat);
         bad = 0;
         for (int k = 0; k < N; k++) begin
            if (pix_bits[k*8 +: 8] !== 8'(exp_pix[k])) bad++;
         end
         checks++;
         if (lat != 17 || bad != 0 || edge_map !== exp_map || edge_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL random_tile%0d lat=%0d badpix=%0d map=%h cnt=%0d required 17 0 %h %0d",
                     t, lat, bad, edge_map, edge_cnt, exp_map, exp_cnt);
         end
         $display("random tile %0d thr=%0d map=%h cnt=%0d", t, thr, edge_map, edge_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int first, second, bad;
      int x2 [N];
      int y2 [N];
      random_tile();
      apply_inputs(60);
      compute_model(60);
      comb_en = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
         x2[k] = $urandom_range(0, 256); y2[k] = $urandom_range(0, 256);
         xm[k] = x2[k]; ym[k] = y2[k];
      end
      apply_inputs(140);
      first = -1;
      for (int e = 1; e <= 18; e++) begin
         @(posedge clk); #1;
         if (comb_done === 1'b1 && first < 0) begin
            first = e;
            checks++;
            if (edge_map !== exp_map || edge_cnt !== CNT_W'(exp_cnt)) begin
               errors++;
               $display("FAIL b2b_first map=%h cnt=%0d required %h %0d", edge_map, edge_cnt, exp_map, exp_cnt);
            end
         end
      end
      checks++;
      if (first != 17 || busy !== 1'b1 || comb_done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_retrigger first=E%0d busy@E18=%b done@E18=%b required E17 1 0", first, busy, comb_done);
      end
      comb_en = 1'b0;
      compute_model(140);
      second = -1;
      for (int e = 19; e <= 40; e++) begin
         @(posedge clk); #1;
         if (comb_done === 1'b1) begin second = e; break; end
      end
      bad = 0;
      for (int k = 0; k < N; k++) begin
         if (pix_bits[k*8 +: 8] !== 8'(exp_pix[k])) bad++;
      end
      checks++;
      if (second != 35 || bad != 0 || edge_map !== exp_map || edge_cnt !== CNT_W'(exp_cnt)) begin
         errors++;
         $display("FAIL b2b_second at=E%0d badpix=%0d map=%h cnt=%0d required E35 0 %h %0d",
                  second, bad, edge_map, edge_cnt, exp_map, exp_cnt);
      end
      $display("back-to-back: done at E%0d and E%0d", first, second);
   endtask

   initial begin
      test_reset();
      test_zero_timing();
      test_directed();
      test_threshold_boundary();
      test_saturation_ignore();
      test_reset_abort();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
